dmem_mmio_responder: RTL and testbench
======================================

// Module: dmem_mmio_responder
// PURPOSE
// - Responder end of the processor's dmem port (address_dmem/data/wren -> q_dmem).
// - Decodes each word address to one of two targets:
//   - a synchronous data RAM;
//   - a small MMIO window: cycle counter, button event FIFO, score register, random source.
// - The game software reads controller buttons and publishes the score through ordinary lw/sw.
// PARAMETERS
// - ADDR_WIDTH  12            RAM word-address bits; RAM holds 2**ADDR_WIDTH words.
// - MMIO_BASE   32'h0000F000  word address of MMIO register 0.
// - BTN_WIDTH   8             number of button inputs, 1..16.
// - FIFO_DEPTH  4             button event FIFO entries; must be a power of 2.
// PORTS
// - clock         in   1          master clock; all state updates on the rising edge.
// - reset         in   1          synchronous, active-high.
// - address_dmem  in   32         word address from the processor memory stage.
// - data          in   32         store data.
// - wren          in   1          write enable.
// - q_dmem        out  32         read data; registered.
// - btn_in        in   BTN_WIDTH  raw button levels; asynchronous to clock.
// - score         out  32         current SCORE register value, for the display logic.
// BEHAVIOUR
// - Address map (word addresses; A = address_dmem):
//   - A < 2**ADDR_WIDTH: RAM.
//   - MMIO_BASE+0  CYCLE (RO): free-running 32-bit counter, +1 every cycle, wraps to 0.
//   - MMIO_BASE+1  STATUS (RW):
//     - read = {ovf[31], 7'b0, count[23:16] zero-extended, 16'(sync_levels)}.
//     - any write clears ovf.
//   - MMIO_BASE+2  EVENT (RW):
//     - read = head entry {tag[31:24], 7'b0, valid[16], 16'(rise_mask)}; reads 0 when the FIFO is empty.
//     - write = acknowledge (see FIFO rules below).
//   - MMIO_BASE+3  SCORE (RW): 32-bit register, drives the score port.
//   - MMIO_BASE+4  RAND (RO): see CONFIGURATION.
//   - Any other address: reads 0, writes ignored.
// - Read latency: q_dmem is updated on every rising edge from the address present at that edge.
//   - Exactly 1 cycle; no read enable.
//   - Read-during-write to the same address returns the old value.
// - Writes take effect at the rising edge where wren=1.
//   - A write held for N cycles (pipeline stall) is applied N times.
//   - Every register is defined so that re-applying the same write is harmless.
// - Buttons:
//   - 2-flop synchroniser, then rising-edge detect against the previous synchronised sample.
//   - rise_mask = sync & ~prev.
//   - Any nonzero rise_mask is one event.
// - FIFO push:
//   - Entry = {tag, rise_mask}; the 8-bit tag counter increments per accepted push and wraps 255->0.
//   - When full, the event is dropped: ovf set sticky, tag unchanged.
// - FIFO pop (acknowledge):
//   - A write to EVENT pops only if the FIFO is non-empty and data[31:24] == head tag.
//   - A repeated (stalled) write therefore pops at most once.
//   - A mismatching tag, or a write when empty, is ignored.
// - Simultaneous push and pop:
//   - Pop is evaluated first; a push into a full FIFO in the same cycle as a valid pop is accepted.
//   - count stays unchanged and ovf is not set.
// - count range is 0..FIFO_DEPTH; read/write pointers wrap modulo FIFO_DEPTH.
// - Reset values:
//   - q_dmem, score, CYCLE, tag, count, pointers, ovf, synchroniser and prev flops: all 0.
//   - LFSR = 16'hACE1.
//   - RAM contents are not reset.
// - Reset asserted mid-operation: all state above returns to reset values on that edge; pending events are lost.
// CONFIGURATION
// - Macro DMEM_MMIO_LFSR_EN.
// - Defined:
//   - 16-bit Fibonacci LFSR, taps 16,14,13,11, advances every cycle, reset seed 16'hACE1.
//   - RAND reads {16'b0, lfsr}.
//   - A write to RAND loads data[15:0] as the seed; a value of 0 is replaced by 16'hACE1.
// - Not defined: no LFSR logic; RAND reads 0 and writes are ignored.
// TESTING
// - Reset, then read MMIO_BASE+0 twice, 3 cycles apart -> second value = first + 3.
//   - Force CYCLE to 32'hFFFFFFFF -> next cycle reads 0.
// - sw 32'h1234 to RAM word 5, then lw word 5 -> q_dmem = 32'h1234 one cycle after the address.
//   - lw 2**ADDR_WIDTH -> 0.
// - Pulse btn_in[2] high -> after 3 cycles EVENT reads 32'h00010004 (tag 0, valid, mask 4).
//   - Write 32'h00000000 to EVENT three cycles in a row -> exactly one pop; STATUS count = 0.
// - Five rising-edge events with FIFO_DEPTH=4 and no acks:
//   - STATUS bit31 = 1, count = 4, head tag = 0.
//   - Write STATUS -> bit31 = 0.
//   - Event arriving in the same cycle as a valid ack while full -> accepted, count stays 4, ovf stays 0.
// - sw 32'd250 to SCORE -> score port = 250 from the next cycle; assert reset -> score = 0.
// - With DMEM_MMIO_LFSR_EN:
//   - RAND right after reset reads 16'hACE1, then a non-repeating sequence.
//   - Write 0 to RAND -> reads 16'hACE1.
// - Without the macro: RAND reads 0.

Source files
------------

// File: rtl/dmem_mmio_responder_if.sv
// Processor dmem port bundle: word address, store data, write enable and registered read data.
interface dmem_mmio_responder_if;
    logic [31:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q_dmem;

    modport master (
        output address_dmem,
        output data,
        output wren,
        input  q_dmem
    );

    modport slave (
        input  address_dmem,
        input  data,
        input  wren,
        output q_dmem
    );
endinterface

// File: rtl/dmem_mmio_responder.sv
// dmem responder: synchronous data RAM plus MMIO window (CYCLE, STATUS, EVENT, SCORE, RAND).
// Optional RAND LFSR is built when DMEM_MMIO_LFSR_EN is defined; otherwise RAND reads 0.
module dmem_mmio_responder #(
    parameter int          ADDR_WIDTH = 12,
    parameter logic [31:0] MMIO_BASE  = 32'h0000F000,
    parameter int          BTN_WIDTH  = 8,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    dmem_mmio_responder_if.slave bus,
    input  logic [BTN_WIDTH-1:0] btn_in,
    output logic [31:0]          score
);

    localparam int RAM_WORDS = 1 << ADDR_WIDTH;
    localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam int ENTRY_W   = 8 + BTN_WIDTH;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        ptr_inc = (p == PTR_LAST) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    // Address decode
    logic [31:0] w_addr;
    logic        w_is_ram;
    logic        w_sel_cycle, w_sel_status, w_sel_event, w_sel_score, w_sel_rand;
    logic        w_wr_status, w_wr_event, w_wr_score;

    assign w_addr       = bus.address_dmem;
    assign w_is_ram     = (w_addr >> ADDR_WIDTH) == 32'd0;
    assign w_sel_cycle  = !w_is_ram && (w_addr == MMIO_BASE);
    assign w_sel_status = !w_is_ram && (w_addr == MMIO_BASE + 32'd1);
    assign w_sel_event  = !w_is_ram && (w_addr == MMIO_BASE + 32'd2);
    assign w_sel_score  = !w_is_ram && (w_addr == MMIO_BASE + 32'd3);
    assign w_sel_rand   = !w_is_ram && (w_addr == MMIO_BASE + 32'd4);
    assign w_wr_status  = bus.wren && w_sel_status;
    assign w_wr_event   = bus.wren && w_sel_event;
    assign w_wr_score   = bus.wren && w_sel_score;

    logic [31:0]          r_mem [RAM_WORDS];
    logic [31:0]          r_q;
    logic [31:0]          r_cycle;
    logic [31:0]          r_score;
    logic [BTN_WIDTH-1:0] r_sync1, r_sync2, r_prev;
    logic [ENTRY_W-1:0]   r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_rd_ptr, r_wr_ptr;
    logic [CNT_W-1:0]     r_count;
    logic [7:0]           r_tag;
    logic                 r_ovf;

    // Button edge detection and FIFO handshake terms
    logic [BTN_WIDTH-1:0] w_rise;
    logic [ENTRY_W-1:0]   w_head;
    logic [7:0]           w_head_tag;
    logic [BTN_WIDTH-1:0] w_head_mask;
    logic                 w_empty, w_full, w_push_req, w_pop, w_push, w_drop;

    assign w_rise      = r_sync2 & ~r_prev;
    assign w_push_req  = |w_rise;
    assign w_head      = r_fifo[r_rd_ptr];
    assign w_head_tag  = w_head[ENTRY_W-1 -: 8];
    assign w_head_mask = w_head[BTN_WIDTH-1:0];
    assign w_empty     = (r_count == {CNT_W{1'b0}});
    assign w_full      = (r_count == CNT_FULL);
    // Pop is resolved first, so a full FIFO can still take a push in the ack cycle.
    assign w_pop       = w_wr_event && !w_empty && (bus.data[31:24] == w_head_tag);
    assign w_push      = w_push_req && (!w_full || w_pop);
    assign w_drop      = w_push_req && !w_push;

    // Data RAM write port; contents survive reset.
    always_ff @(posedge clock) begin
        if (bus.wren && w_is_ram) begin
            r_mem[w_addr[ADDR_WIDTH-1:0]] <= bus.data;
        end
    end

    // Two-flop synchroniser plus previous-sample register for edge detect.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1 <= {BTN_WIDTH{1'b0}};
            r_sync2 <= {BTN_WIDTH{1'b0}};
            r_prev  <= {BTN_WIDTH{1'b0}};
        end else begin
            r_sync1 <= btn_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // Event FIFO storage; stale entries are harmless because count gates visibility.
    always_ff @(posedge clock) begin
        if (!reset && w_push) begin
            r_fifo[r_wr_ptr] <= {r_tag, w_rise};
        end
    end

    // Event FIFO pointers, occupancy, tag counter and sticky overflow.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rd_ptr <= {PTR_W{1'b0}};
            r_wr_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
            r_tag    <= 8'd0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
                r_tag    <= r_tag + 8'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            // A drop in the same cycle as a clearing write keeps the flag set.
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (w_wr_status) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Free-running cycle counter and software score register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cycle <= 32'd0;
            r_score <= 32'd0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            if (w_wr_score) begin
                r_score <= bus.data;
            end
        end
    end

    logic [31:0] w_rand_rd;

`ifdef DMEM_MMIO_LFSR_EN
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    logic [15:0] r_lfsr;
    logic        w_lfsr_fb;

    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_rand_rd = {16'd0, r_lfsr};

    // Fibonacci LFSR (taps 16,14,13,11); a zero seed would lock it up, so it is replaced.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_lfsr <= LFSR_SEED;
        end else if (bus.wren && w_sel_rand) begin
            r_lfsr <= (bus.data[15:0] == 16'd0) ? LFSR_SEED : bus.data[15:0];
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
        end
    end
`else
    assign w_rand_rd = 32'd0;
`endif

    // MMIO read mux; unmapped addresses read zero.
    logic [31:0] w_mmio_rd;
    always_comb begin
        w_mmio_rd = 32'd0;
        if (w_sel_cycle) begin
            w_mmio_rd = r_cycle;
        end else if (w_sel_status) begin
            w_mmio_rd = {r_ovf, 7'd0, 8'(r_count), 16'(r_sync2)};
        end else if (w_sel_event) begin
            w_mmio_rd = w_empty ? 32'd0 : {w_head_tag, 7'd0, 1'b1, 16'(w_head_mask)};
        end else if (w_sel_score) begin
            w_mmio_rd = r_score;
        end else if (w_sel_rand) begin
            w_mmio_rd = w_rand_rd;
        end else begin
            w_mmio_rd = 32'd0;
        end
    end

    // Registered read data: values before this edge's writes (read-old on collision).
    always_ff @(posedge clock) begin
        if (reset) begin
            r_q <= 32'd0;
        end else if (w_is_ram) begin
            r_q <= r_mem[w_addr[ADDR_WIDTH-1:0]];
        end else begin
            r_q <= w_mmio_rd;
        end
    end

    assign bus.q_dmem = r_q;
    assign score      = r_score;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Self-checking bench for dmem_mmio_responder: vector table, button/FIFO sequences, LFSR and random RAM/SCORE traffic.
module tb_dmem_mmio_responder;

    localparam logic [31:0] BASE   = 32'h0000F000;
    localparam logic [31:0] A_CYC  = BASE;
    localparam logic [31:0] A_STAT = BASE + 32'd1;
    localparam logic [31:0] A_EVT  = BASE + 32'd2;
    localparam logic [31:0] A_SCR  = BASE + 32'd3;
    localparam logic [31:0] A_RND  = BASE + 32'd4;

    logic        clock;
    logic        reset;
    logic [7:0]  btn_in;
    logic [31:0] score;
    logic [31:0] q;
    logic [31:0] cyc_m;
    logic [31:0] cyc_exp;
    int          checks;
    int          failures;

    dmem_mmio_responder_if bus_if ();

    dmem_mmio_responder #(
        .ADDR_WIDTH (12),
        .MMIO_BASE  (BASE),
        .BTN_WIDTH  (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .bus    (bus_if),
        .btn_in (btn_in),
        .score  (score)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wren;
        logic        chk;
        logic [31:0] exp;
        string       name;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // One bus cycle: drive, clock, sample read data away from the edge.
    task automatic step(input logic [31:0] a, input logic [31:0] d, input logic w);
        bus_if.address_dmem = a;
        bus_if.data         = d;
        bus_if.wren         = w;
        cyc_exp = cyc_m;
        @(posedge clock);
        cyc_m = reset ? 32'd0 : cyc_m + 32'd1;
        @(negedge clock);
        q = bus_if.q_dmem;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        btn_in = 8'd0;
        step(32'd0, 32'd0, 1'b0);
        step(32'd0, 32'd0, 1'b0);
        check("reset_q", q, 32'd0);
        check("reset_score", score, 32'd0);
        reset = 1'b0;
    endtask

    // One clean button press: 3 cycles high then 3 low so the next press is a fresh edge.
    task automatic press(input logic [7:0] m);
        btn_in = m;
        repeat (3) step(A_CYC, 32'd0, 1'b0);
        btn_in = 8'd0;
        repeat (3) step(A_CYC, 32'd0, 1'b0);
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        logic fb;
        fb = ^(l & 16'hB400);
        return {l[14:0], fb};
    endfunction

    vec_t        vecs[18];
    logic [31:0] ram_m [logic [31:0]];
    logic [31:0] score_m;
    logic [31:0] c0;
    logic [15:0] lf;
    int          lat;

    initial begin
        checks   = 0;
        failures = 0;
        cyc_m    = 32'd0;
        bus_if.address_dmem = 32'd0;
        bus_if.data = 32'd0;
        bus_if.wren = 1'b0;
        btn_in = 8'd0;
        reset = 1'b1;

        vecs[0]  = '{32'd5,      32'h1234,     1'b1, 1'b0, 32'd0,        "ram_wr5"};
        vecs[1]  = '{32'd5,      32'd0,        1'b0, 1'b1, 32'h1234,     "ram_rd5"};
        vecs[2]  = '{32'd4096,   32'd0,        1'b0, 1'b1, 32'd0,        "ram_oob_rd"};
        vecs[3]  = '{A_SCR,      32'd250,      1'b1, 1'b1, 32'd0,        "score_wr"};
        vecs[4]  = '{A_SCR,      32'd0,        1'b0, 1'b1, 32'd250,      "score_rd"};
        vecs[5]  = '{A_SCR,      32'd250,      1'b1, 1'b1, 32'd250,      "score_rewr"};
        vecs[6]  = '{A_STAT,     32'd0,        1'b0, 1'b1, 32'd0,        "status_idle"};
        vecs[7]  = '{A_EVT,      32'd0,        1'b0, 1'b1, 32'd0,        "event_empty"};
        vecs[8]  = '{A_EVT,      32'd0,        1'b1, 1'b1, 32'd0,        "event_ack_empty"};
        vecs[9]  = '{BASE + 5,   32'd0,        1'b0, 1'b1, 32'd0,        "hole_rd"};
        vecs[10] = '{BASE + 5,   32'd77,       1'b1, 1'b1, 32'd0,        "hole_wr"};
        vecs[11] = '{BASE + 5,   32'd0,        1'b0, 1'b1, 32'd0,        "hole_rd2"};
        vecs[12] = '{32'hFFF,    32'hDEADBEEF, 1'b1, 1'b0, 32'd0,        "ram_wr_top"};
        vecs[13] = '{32'hFFF,    32'd0,        1'b0, 1'b1, 32'hDEADBEEF, "ram_rd_top"};
        vecs[14] = '{32'h1005,   32'h55,       1'b1, 1'b1, 32'd0,        "oob_wr"};
        vecs[15] = '{32'd5,      32'd0,        1'b0, 1'b1, 32'h1234,     "ram_rd5_noalias"};
        vecs[16] = '{32'd5,      32'hAAAA,     1'b1, 1'b1, 32'h1234,     "ram_rdw_old"};
        vecs[17] = '{32'd5,      32'd0,        1'b0, 1'b1, 32'hAAAA,     "ram_rd5_new"};

        do_reset();

        for (int i = 0; i < 18; i++) begin
            step(vecs[i].addr, vecs[i].wdata, vecs[i].wren);
            if (vecs[i].chk) check(vecs[i].name, q, vecs[i].exp);
        end
        check("score_port", score, 32'd250);

        // CYCLE: two reads three cycles apart differ by exactly 3
        step(A_CYC, 32'd0, 1'b0);
        c0 = q;
        check("cycle_model", q, cyc_exp);
        step(32'd0, 32'd0, 1'b0);
        step(32'd0, 32'd0, 1'b0);
        step(A_CYC, 32'hFFFFFFFF, 1'b1);
        check("cycle_plus3", q, c0 + 32'd3);

        // Single press of button 2, then a stalled triple acknowledge
        btn_in = 8'h04;
        lat = 0;
        q = 32'd0;
        while (q == 32'd0 && lat < 8) begin
            step(A_EVT, 32'd0, 1'b0);
            lat++;
        end
        check("event_value", q, 32'h00010004);
        check("event_latency", 32'(lat), 32'd4);
        btn_in = 8'd0;
        step(A_EVT, 32'h00000000, 1'b1);
        check("ack1_old_head", q, 32'h00010004);
        step(A_EVT, 32'h00000000, 1'b1);
        check("ack2_empty", q, 32'd0);
        step(A_EVT, 32'h00000000, 1'b1);
        step(A_STAT, 32'd0, 1'b0);
        check("status_after_ack", q, 32'd0);

        // Overflow: five presses into a 4-deep FIFO
        do_reset();
        for (int k = 0; k < 5; k++) press(8'h01);
        step(A_STAT, 32'd0, 1'b0);
        check("ovf_status", q, 32'h80040000);
        step(A_EVT, 32'd0, 1'b0);
        check("ovf_head", q, 32'h00010001);
        step(A_STAT, 32'h12345678, 1'b1);
        step(A_STAT, 32'd0, 1'b0);
        check("ovf_cleared", q, 32'h00040000);

        // Push into a full FIFO in the same edge as a valid ack
        btn_in = 8'h01;
        step(A_CYC, 32'd0, 1'b0);
        step(A_CYC, 32'd0, 1'b0);
        step(A_EVT, 32'h00000000, 1'b1);
        check("simul_ack_head", q, 32'h00010001);
        step(A_STAT, 32'd0, 1'b0);
        check("simul_status", q, 32'h00040001);
        step(A_EVT, 32'h00000000, 1'b1);
        check("bad_tag_ignored", q, 32'h01010001);
        step(A_EVT, 32'd0, 1'b0);
        check("bad_tag_head", q, 32'h01010001);
        for (int t = 1; t <= 3; t++) begin
            step(A_EVT, {8'(t), 24'd0}, 1'b1);
            step(A_EVT, {8'(t), 24'd0}, 1'b1);
        end
        step(A_EVT, 32'd0, 1'b0);
        check("tag_after_drop", q, 32'h04010001);
        btn_in = 8'd0;

        // Score survives until reset
        step(A_SCR, 32'd250, 1'b1);
        check("score_wr_port", score, 32'd250);
        do_reset();

`ifdef DMEM_MMIO_LFSR_EN
        lf = 16'hACE1;
        for (int i = 0; i < 6; i++) begin
            step(A_RND, 32'd0, 1'b0);
            check("rand_seq", q, {16'd0, lf});
            lf = lfsr_next(lf);
        end
        step(A_RND, 32'd0, 1'b1);
        step(A_RND, 32'd0, 1'b0);
        check("rand_zero_seed", q, 32'h0000ACE1);
        step(A_RND, 32'h00001234, 1'b1);
        step(A_RND, 32'd0, 1'b0);
        check("rand_seed_load", q, 32'h00001234);
`else
        lf = 16'd0;
        step(A_RND, 32'd0, 1'b0);
        check("rand_off_rd", q, 32'd0);
        step(A_RND, 32'h0000BEEF, 1'b1);
        step(A_RND, 32'd0, 1'b0);
        check("rand_off_wr", q, {16'd0, lf});
`endif

        // Random traffic against a high-level model (RAM map, score, cycle count)
        do_reset();
        score_m = 32'd0;
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            logic [31:0] d;
            logic        w;
            logic        known;
            logic [31:0] e;
            case ($urandom_range(0, 6))
                0, 1:    a = 32'($urandom_range(0, 15));
                2:       a = 32'($urandom_range(4088, 4095));
                3:       a = A_SCR;
                4:       a = A_CYC;
                5:       a = A_STAT;
                default: a = 32'h00001000 + 32'($urandom_range(0, 3));
            endcase
            d = $urandom;
            w = 1'($urandom_range(0, 1));
            known = 1'b1;
            e = 32'd0;
            if (a < 32'd4096) begin
                known = ram_m.exists(a);
                if (known) e = ram_m[a];
            end else if (a == A_SCR) begin
                e = score_m;
            end
            step(a, d, w);
            if (a == A_CYC) e = cyc_exp;
            if (known) check("rand_rd", q, e);
            if (w) begin
                if (a < 32'd4096) ram_m[a] = d;
                else if (a == A_SCR) score_m = d;
            end
            check("rand_score_port", score, score_m);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
